// File: rtl/calc_operand_entry.sv
// Operand-entry controller: synchronises/debounces enter and clear buttons and
// sequences A -> operator -> B -> show. Debounce counters present only when CALC_DEBOUNCE_EN is defined.
module calc_operand_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sw,
  input  logic       op_sel,
  input  logic       btn_enter,
  input  logic       btn_clear,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic       M,
  output logic       valid,
  output logic       new_calc,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_OP   = 2'b01,
    S_B    = 2'b10,
    S_SHOW = 2'b11
  } state_t;

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_param_check
    $error("DEBOUNCE_CYCLES must be in 2..65535");
  end

  // Bit 0 = enter, bit 1 = clear; both buttons share one conditioning path.
  logic [1:0] btn_raw;
  logic [1:0] sync1, sync2;
  logic [1:0] stable, stable_q;
  logic [1:0] press;

  assign btn_raw = {btn_clear, btn_enter};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      stable_q <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      stable_q <= stable;
    end
  end

`ifdef CALC_DEBOUNCE_EN
  localparam int CW = 16;
  logic [CW-1:0] cnt [2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt[i]    <= '0;
          stable[i] <= ~stable[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign stable = sync2;
`endif

  // Rising edge of the stable level only; releases are ignored.
  assign press = stable & ~stable_q;

  state_t     state_q, state_d;
  logic [2:0] a_q, a_d, b_q, b_d;
  logic       m_q, m_d, valid_q, valid_d, new_calc_q, new_calc_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_A;
      a_q        <= '0;
      b_q        <= '0;
      m_q        <= 1'b0;
      valid_q    <= 1'b0;
      new_calc_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      m_q        <= m_d;
      valid_q    <= valid_d;
      new_calc_q <= new_calc_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    m_d        = m_q;
    valid_d    = valid_q;
    new_calc_d = 1'b0;
    if (press[1]) begin
      // Clear outranks a coincident enter.
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      m_d     = 1'b0;
      valid_d = 1'b0;
    end else if (press[0]) begin
      unique case (state_q)
        S_A: begin
          a_d     = sw;
          state_d = S_OP;
        end
        S_OP: begin
          m_d     = op_sel;
          state_d = S_B;
        end
        S_B: begin
          b_d        = sw;
          valid_d    = 1'b1;
          new_calc_d = 1'b1;
          state_d    = S_SHOW;
        end
        S_SHOW: begin
          valid_d = 1'b0;
          state_d = S_A;
        end
        default: state_d = S_A;
      endcase
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign M        = m_q;
  assign valid    = valid_q;
  assign new_calc = new_calc_q;
  assign phase    = state_q;

endmodule

// File: tb/tb_calc_operand_entry.sv
// Self-checking bench for calc_operand_entry: directed scenarios plus random
// button sequences against an abstract entry-sequence model.
module tb_calc_operand_entry;

  localparam int DB = 16;
`ifdef CALC_DEBOUNCE_EN
  localparam int LAT = DB + 3;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sw = 3'b000;
  logic       op_sel = 1'b0;
  logic       btn_enter = 1'b0;
  logic       btn_clear = 1'b0;
  logic [2:0] A, B;
  logic       M, valid, new_calc;
  logic [1:0] phase;

  calc_operand_entry #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .op_sel(op_sel),
    .btn_enter(btn_enter), .btn_clear(btn_clear),
    .A(A), .B(B), .M(M), .valid(valid), .new_calc(new_calc), .phase(phase)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: which step of the entry we are at (0..3) and the captured values.
  int         ms = 0;
  logic [2:0] ma = '0, mb = '0;
  logic       mm = 1'b0, mv = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ms = 0; ma = '0; mb = '0; mm = 1'b0; mv = 1'b0;
  endtask

  task automatic model_apply(input bit en, input bit cl, input logic [2:0] s, input logic o);
    if (cl) model_reset();
    else if (en) begin
      case (ms)
        0: begin ma = s; ms = 1; end
        1: begin mm = o; ms = 2; end
        2: begin mb = s; mv = 1'b1; ms = 3; end
        default: begin mv = 1'b0; ms = 0; end
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".A"}, 32'(A), 32'(ma));
    check({tag, ".B"}, 32'(B), 32'(mb));
    check({tag, ".M"}, 32'(M), 32'(mm));
    check({tag, ".valid"}, 32'(valid), 32'(mv));
    check({tag, ".phase"}, 32'(phase), 32'(ms));
  endtask

  // Hold the button(s) long enough to register, release, and let the release settle.
  task automatic press(input string tag, input bit en, input bit cl,
                       input logic [2:0] s, input logic o);
    int  old_ms, change_at, pulses;
    bit  exp_pulse;
    old_ms    = ms;
    exp_pulse = en && !cl && (ms == 2);
    change_at = -1;
    pulses    = 0;
    @(negedge clk);
    sw = s; op_sel = o; btn_enter = en; btn_clear = cl;
    for (int e = 1; e <= LAT + 4; e++) begin
      @(posedge clk); #1;
      if (new_calc === 1'b1) pulses++;
      if (change_at < 0 && phase !== 2'(old_ms)) change_at = e;
    end
    @(negedge clk);
    btn_enter = 1'b0; btn_clear = 1'b0;
    for (int e = 1; e <= LAT + 4; e++) begin
      @(posedge clk); #1;
      if (new_calc === 1'b1) pulses++;
    end
    model_apply(en, cl, s, o);
    if (ms != old_ms) check({tag, ".latency"}, 32'(change_at), 32'(LAT));
    check({tag, ".new_calc_pulses"}, 32'(pulses), 32'(exp_pulse));
    check_all(tag);
    sw = 3'($urandom); op_sel = 1'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    // Reset held for two edges with buttons idle.
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    check("reset.new_calc", 32'(new_calc), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Full entry: 3 - (-2).
    press("entry_a", 1, 0, 3'b011, 1'b0);
    press("entry_op", 1, 0, 3'b000, 1'b1);
    press("entry_b", 1, 0, 3'b110, 1'b0);
    press("show_exit", 1, 0, 3'b101, 1'b0);

`ifdef CALC_DEBOUNCE_EN
    // Bounce: 10 high, 3 low, 10 high must not register.
    pulses = 0;
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      btn_enter = (i < 10 || i >= 13);
    end
    @(negedge clk) btn_enter = 1'b0;
    for (int e = 0; e < LAT + 4; e++) begin
      @(posedge clk); #1;
      if (phase !== 2'b00) pulses++;
    end
    check("bounce.phase_moves", 32'(pulses), 32'd0);
    check("bounce.phase", 32'(phase), 32'd0);
`endif

    // Clear in S_B after A=010, M=0.
    press("clr_a", 1, 0, 3'b010, 1'b1);
    press("clr_op", 1, 0, 3'b111, 1'b0);
    press("clr_in_b", 0, 1, 3'b001, 1'b1);

    // Enter and clear together in S_OP.
    press("both_a", 1, 0, 3'b101, 1'b0);
    press("both_in_op", 1, 1, 3'b011, 1'b1);

    // Clear in S_A keeps phase.
    press("clr_in_a", 0, 1, 3'b011, 1'b1);

    // -4 passes through bit-exact; then reset during show.
    press("neg_a", 1, 0, 3'b100, 1'b0);
    press("neg_op", 1, 0, 3'b000, 1'b1);
    press("neg_b", 1, 0, 3'b100, 1'b0);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check_all("mid_show_reset");
    check("mid_show_reset.new_calc", 32'(new_calc), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Random button traffic.
    for (int i = 0; i < 24; i++) begin
      int r;
      r = $urandom_range(0, 9);
      press($sformatf("rand%0d", i), (r < 7) || (r == 9), (r >= 7),
            3'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
